uart_sim_monitor: RTL and testbench
===================================

# uart_sim_monitor

Simulation-side UART receive monitor that sits on the system UART transmit pin (`OUT_PIN_SER0_TX`), alongside the virtual UART DPI model in the Verilator top level. It deserialises 8N1 frames from the pin, presents each decoded byte as a one-cycle strobe, and counts bytes. It watches the byte stream for the tokens "PASS" and "FAIL" so the testbench can end the simulation and report a verdict without parsing DPI output.

## Interface
Parameters:
- `ClkFreq`, 30_000_000: clock frequency in Hz.
- `BaudRate`, 921_600: line rate in bits per second.
- `CountW`, 16: width of the byte counter.

Ports:
- `clk_i`  in  1  system clock; the block has one clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `rx_i`  in  1  serial line from the system UART TX; idle-high; may change at any time.
- `byte_valid_o`  out  1  one-cycle strobe; a byte was received with a good stop bit.
- `byte_o`  out  8  received byte; valid while `byte_valid_o` is high; holds its last value otherwise.
- `frame_err_o`  out  1  one-cycle strobe; the stop bit was sampled low.
- `byte_count_o`  out  CountW  number of good bytes received; saturates at all-ones.
- `pass_o`  out  1  sticky; "PASS" was seen.
- `fail_o`  out  1  sticky; "FAIL" was seen.

## Operation
- Derived constants:
  - `CyclesPerBit` = `ClkFreq`/`BaudRate`, integer division; 32 with the defaults.
  - `HalfBit` = `CyclesPerBit`/2; 16 with the defaults.
  - Elaboration fails if `CyclesPerBit` < 4.
- Input path:
  - `rx_i` passes through a 2-flop synchroniser; its output is `rx_s`.
  - Both synchroniser flops reset to 1, so leaving reset never produces a spurious start bit.
- Receiver FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - In the first cycle `rx_s`=0 (call it t0), load the bit counter and go to START.
- START:
  - At t0+`HalfBit`, sample `rx_s`.
  - If 0, go to DATA.
  - If 1, the low was a glitch: return to IDLE with no output.
- DATA:
  - Sample bit n (n=0..7, LSB first) at t0+`HalfBit`+(n+1)·`CyclesPerBit`.
  - Shift each sample into the data register.
  - After bit 7, go to STOP.
- STOP:
  - Sample at t0+`HalfBit`+9·`CyclesPerBit`.
  - If 1: go to IDLE; the next cycle asserts `byte_valid_o` with `byte_o`.
  - If 0: go to BREAK; the next cycle asserts `frame_err_o`.
- BREAK:
  - Stay until `rx_s`=1, then go to IDLE.
  - A held-low line never produces repeated frames.
- Back-to-back frames:
  - IDLE is entered at the stop-bit sample, so a start edge that follows immediately is accepted.
- Byte counter:
  - Increments on each `byte_valid_o`.
  - At all-ones it holds; it does not wrap.
- Token matcher:
  - A 4-byte history register shifts on each good byte (newest byte in the low position).
  - A frame error clears the history to 0.
  - History equal to "PASS" (0x50 0x41 0x53 0x53, oldest first) sets `pass_o`.
  - History equal to "FAIL" (0x46 0x41 0x49 0x4C, oldest first) sets `fail_o`.
  - The first verdict wins. Once either flag is set, neither flag changes until reset; byte decoding and counting continue.
- Reset values:
  - All outputs are 0; `byte_o` is 0x00.
  - The FSM is in IDLE; the history is 0.
  - Reset in any state, including mid-frame, discards the partial byte and gives no strobe.

## Timing
- From an `rx_i` change to `rx_s`: 2 cycles.
- From t0 to `byte_valid_o`: `HalfBit`+9·`CyclesPerBit`+1 cycles; 305 with the defaults.
- `byte_count_o` updates in the same cycle as `byte_valid_o`.
- `pass_o`/`fail_o` rise 1 cycle after the `byte_valid_o` of the final token byte.
- `byte_valid_o` and `frame_err_o` are never high in the same cycle.
- Each strobe is exactly one cycle wide.
- No backpressure: consumers must take `byte_o` during the strobe cycle.

## Structure
- Shared package `uart_sim_pkg` holds:
  - the FSM state enum `uart_rx_state_e`;
  - token constants `TokenPass` and `TokenFail` (32-bit, oldest byte in the MSBs);
  - the function that computes `CyclesPerBit`.
- Sub-module `uart_sim_rx` contains the synchroniser, the bit counter, the FSM and the data shifter; it produces `byte_valid_o`, `byte_o` and `frame_err_o`.
- `uart_sim_monitor` instantiates `uart_sim_rx` and adds the byte counter and the token matcher.

## Test plan
- Drive 0x55 at 32 cycles/bit, with t0 as defined above → `byte_valid_o` at t0+305 with `byte_o`=0x55; `byte_count_o`=1.
- Send "xPASS" back-to-back with no idle gap → five strobes; `pass_o`=1 one cycle after the fifth strobe; `fail_o`=0.
- Send "PASS" then "FAIL" → `pass_o` stays 1; `fail_o` stays 0; `byte_count_o`=8.
- Pull `rx_i` low for 10 cycles, then high → no strobes; FSM back in IDLE; a following 0xA3 frame decodes correctly.
- Send a frame with stop bit 0, then hold the line low for 200 cycles → exactly one `frame_err_o`, no `byte_valid_o`, history cleared. Then send "FAIL" → `fail_o`=1.
- Assert `rst_i` at data bit 4 of a frame → all outputs 0 in the next cycle; bytes sent after reset decode with `byte_count_o` starting from 1.
- Set `CountW`=2 and send 5 bytes → `byte_count_o` saturates at 3.

Source files
------------

// File: rtl/uart_sim_pkg.sv
// Shared types and constants for the simulation-side UART receive monitor.
package uart_sim_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } uart_rx_state_e;

  // Verdict tokens, oldest byte in the MSBs
  localparam logic [31:0] TokenPass = 32'h5041_5353;  // "PASS"
  localparam logic [31:0] TokenFail = 32'h4641_494C;  // "FAIL"

  // Whole clock cycles per serial bit (integer division)
  function automatic int cycles_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sim_rx.sv
// 8N1 deserialiser: input synchroniser, bit timing counter, receive FSM and data shifter.
module uart_sim_rx #(
  parameter int ClkFreq  = 30_000_000,
  parameter int BaudRate = 921_600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       byte_done_o,   // stop bit sampled good this cycle (strobe follows next cycle)
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);
  import uart_sim_pkg::*;

  localparam int CyclesPerBit = cycles_per_bit(ClkFreq, BaudRate);
  localparam int HalfBit      = CyclesPerBit / 2;
  localparam int CntW         = $clog2(CyclesPerBit);
  localparam int SyncStages   = 2;

  localparam logic [CntW-1:0] HalfLoad = CntW'(HalfBit - 1);
  localparam logic [CntW-1:0] BitLoad  = CntW'(CyclesPerBit - 1);

  // Bit timing needs a few cycles per bit to find the middle of each bit
  if (CyclesPerBit < 4) begin : g_bad_rate
    $error("uart_sim_rx: ClkFreq/BaudRate must be at least 4");
  end

  logic [SyncStages:0] sync_chain;
  logic                rx_s;

  uart_rx_state_e state_reg, state_next;
  logic [CntW-1:0] cnt_reg, cnt_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      shift_reg, shift_next;
  logic [7:0]      byte_reg;
  logic            valid_reg, err_reg;
  logic            done_next, err_next;

  assign sync_chain[0] = rx_i;
  assign rx_s          = sync_chain[SyncStages];

  // Synchroniser stages reset to the idle-high level so reset release never looks like a start bit
  for (genvar gi = 0; gi < SyncStages; gi++) begin : g_sync
    always_ff @(posedge clk_i) begin
      if (rst_i) sync_chain[gi+1] <= 1'b1;
      else       sync_chain[gi+1] <= sync_chain[gi];
    end
  end

  // FSM, timing counter, shifter and output strobe registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= RX_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      byte_reg  <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      valid_reg <= done_next;
      err_reg   <= err_next;
      if (done_next) byte_reg <= shift_reg;
    end
  end

  // Next-state logic: the counter expires at the middle of each bit, where rx_s is sampled
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        if (!rx_s) begin
          cnt_next   = HalfLoad;
          state_next = RX_START;
        end
      end
      RX_START: begin
        if (cnt_reg == '0) begin
          if (!rx_s) begin
            cnt_next   = BitLoad;
            bit_next   = '0;
            state_next = RX_DATA;
          end else begin
            state_next = RX_IDLE;  // start bit did not hold: glitch
          end
        end else begin
          cnt_next = cnt_reg - CntW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_reg == '0) begin
          shift_next = {rx_s, shift_reg[7:1]};  // LSB arrives first
          cnt_next   = BitLoad;
          if (bit_reg == 3'd7) state_next = RX_STOP;
          else                 bit_next   = bit_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg - CntW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_reg == '0) begin
          if (rx_s) begin
            done_next  = 1'b1;
            state_next = RX_IDLE;  // back in IDLE mid-stop so a following start edge is caught
          end else begin
            err_next   = 1'b1;
            state_next = RX_BREAK;
          end
        end else begin
          cnt_next = cnt_reg - CntW'(1);
        end
      end
      RX_BREAK: begin
        if (rx_s) state_next = RX_IDLE;
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign byte_done_o  = done_next;
  assign byte_valid_o = valid_reg;
  assign byte_o       = byte_reg;
  assign frame_err_o  = err_reg;

endmodule

// File: rtl/uart_sim_monitor.sv
// UART TX pin monitor: decoded byte strobes, saturating byte count and PASS/FAIL token detection.
module uart_sim_monitor #(
  parameter int ClkFreq  = 30_000_000,
  parameter int BaudRate = 921_600,
  parameter int CountW   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_i,
  output logic              byte_valid_o,
  output logic [7:0]        byte_o,
  output logic              frame_err_o,
  output logic [CountW-1:0] byte_count_o,
  output logic              pass_o,
  output logic              fail_o
);
  import uart_sim_pkg::*;

  localparam logic [CountW-1:0] CountMax = {CountW{1'b1}};

  logic              byte_done;
  logic [CountW-1:0] count_reg;
  logic [31:0]       hist_reg;
  logic [31:0]       hist_cand;
  logic              pass_reg, fail_reg;

  uart_sim_rx #(
    .ClkFreq  (ClkFreq),
    .BaudRate (BaudRate)
  ) u_rx (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rx_i         (rx_i),
    .byte_done_o  (byte_done),
    .byte_valid_o (byte_valid_o),
    .byte_o       (byte_o),
    .frame_err_o  (frame_err_o)
  );

  // Count advances on the cycle before the strobe so it reads updated during the strobe
  always_ff @(posedge clk_i) begin
    if (rst_i)                                count_reg <= '0;
    else if (byte_done && count_reg != CountMax) count_reg <= count_reg + CountW'(1);
  end

  // Last four good bytes, newest in the low byte; a framing error breaks any partial token
  always_ff @(posedge clk_i) begin
    if (rst_i)             hist_reg <= '0;
    else if (frame_err_o)  hist_reg <= '0;
    else if (byte_valid_o) hist_reg <= {hist_reg[23:0], byte_o};
  end

  // History as it will be once the strobed byte is shifted in
  assign hist_cand = {hist_reg[23:0], byte_o};

  // Sticky verdict; the first token seen locks both flags until reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pass_reg <= 1'b0;
      fail_reg <= 1'b0;
    end else if (byte_valid_o && !pass_reg && !fail_reg) begin
      if (hist_cand == TokenPass) pass_reg <= 1'b1;
      if (hist_cand == TokenFail) fail_reg <= 1'b1;
    end
  end

  assign byte_count_o = count_reg;
  assign pass_o       = pass_reg;
  assign fail_o       = fail_reg;

endmodule

// File: tb/tb_uart_sim_monitor.sv
// Randomised self-checking bench for uart_sim_monitor against a byte-level reference model.
module tb_uart_sim_monitor;

  localparam int Cpb = 32;   // 30 MHz / 921600 baud
  localparam int Lat = 307;  // drive-low to strobe: 2 sync cycles + HalfBit + 9*Cpb + 1

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        rx_i = 1'b1;
  logic        byte_valid_o, frame_err_o, pass_o, fail_o;
  logic [7:0]  byte_o;
  logic [15:0] byte_count_o;
  logic        valid2, err2, pass2, fail2;
  logic [7:0]  byte2;
  logic [1:0]  count2;

  uart_sim_monitor dut (
    .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i),
    .byte_valid_o(byte_valid_o), .byte_o(byte_o), .frame_err_o(frame_err_o),
    .byte_count_o(byte_count_o), .pass_o(pass_o), .fail_o(fail_o)
  );

  uart_sim_monitor #(.CountW(2)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i),
    .byte_valid_o(valid2), .byte_o(byte2), .frame_err_o(err2),
    .byte_count_o(count2), .pass_o(pass2), .fail_o(fail2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_vec = 0;
  int n_err = 0;

  // Expected event: val 0..255 is a good byte, 256 a framing error; due is the strobe cycle
  typedef struct { int val; int due; } exp_t;
  exp_t     exp_q[$];
  int       m_good;
  logic     m_pass, m_fail;
  logic [7:0] m_last;
  byte      recent[$];
  bit       mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic bit seen_token(input string s);
    if (recent.size() != 4) return 1'b0;
    for (int i = 0; i < 4; i++) if (recent[i] != s[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Monitor: compares every strobe against the expected event queue
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("strobe_excl", {31'b0, byte_valid_o & frame_err_o}, 32'd0);
      chk("pass_o", {31'b0, pass_o}, {31'b0, m_pass});
      chk("fail_o", {31'b0, fail_o}, {31'b0, m_fail});
      chk("pass2", {31'b0, pass2}, {31'b0, m_pass});
      if (byte_valid_o || frame_err_o) begin
        if (exp_q.size() == 0) begin
          chk("extra_strobe", {31'b0, byte_valid_o | frame_err_o}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("latency", cyc, e.due);
          if (e.val == 256) begin
            chk("frame_err", {31'b0, frame_err_o}, 32'd1);
            chk("err2", {31'b0, err2}, 32'd1);
            recent.delete();
          end else begin
            chk("byte_valid", {31'b0, byte_valid_o}, 32'd1);
            chk("byte_o", byte_o, e.val);
            chk("byte2", byte2, e.val);
            m_good++;
            m_last = e.val[7:0];
            recent.push_back(byte'(e.val));
            if (recent.size() > 4) void'(recent.pop_front());
            chk("byte_count", byte_count_o, sat(m_good, 65535));
            chk("count2_sat", count2, sat(m_good, 3));
            if (!m_pass && !m_fail) begin
              if (seen_token("PASS"))      m_pass = 1'b1;
              else if (seen_token("FAIL")) m_fail = 1'b1;
            end
          end
        end
      end else begin
        chk("byte_hold", byte_o, m_last);
        if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
          chk("missing_strobe", cyc, exp_q[0].due);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame; a low stop bit leaves the line low for the caller
  task automatic send(input logic [7:0] b, input bit stop_ok);
    exp_t e;
    @(negedge clk);
    e.val = stop_ok ? int'(b) : 256;
    e.due = cyc + Lat;
    exp_q.push_back(e);
    rx_i = 1'b0;
    repeat (Cpb - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx_i = b[i];
      repeat (Cpb - 1) @(negedge clk);
    end
    @(negedge clk);
    rx_i = stop_ok;
    repeat (Cpb - 1) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i], 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    rst_i  = 1'b1;
    rx_i   = 1'b1;
    exp_q.delete();
    recent.delete();
    m_good = 0;
    m_pass = 1'b0;
    m_fail = 1'b0;
    m_last = 8'h00;
    @(negedge clk);
    chk("rst_valid", {31'b0, byte_valid_o}, 32'd0);
    chk("rst_err", {31'b0, frame_err_o}, 32'd0);
    chk("rst_byte", byte_o, 32'd0);
    chk("rst_count", byte_count_o, 32'd0);
    chk("rst_pass", {31'b0, pass_o}, 32'd0);
    chk("rst_fail", {31'b0, fail_o}, 32'd0);
    chk("rst_count2", count2, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  initial begin
    int wait_cyc;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    do_reset();
    idle(10);

    // Single byte, fixed latency and first count
    send(8'h55, 1'b1);
    idle(20);
    chk("count_after_55", byte_count_o, 32'd1);

    // Short low pulse is rejected, next frame still decodes
    @(negedge clk);
    rx_i = 1'b0;
    repeat (10) @(negedge clk);
    idle(40);
    send(8'hA3, 1'b1);
    idle(20);

    // Random bytes, random gaps (including none), occasional bad stop bit
    for (int k = 0; k < 14; k++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) begin
        send(b, 1'b0);
        idle($urandom_range(3, 8));
      end else begin
        send(b, 1'b1);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 6));
      end
    end
    idle(20);

    // Partial token, framing error with long break, then remainder: no verdict
    send_str("FAI");
    send(8'($urandom_range(0, 255)), 1'b0);
    repeat (200) @(negedge clk);
    idle(10);
    send("L", 1'b1);
    idle(20);
    chk("fail_after_break_split", {31'b0, fail_o}, 32'd0);
    send_str("FAIL");
    idle(20);
    chk("fail_set", {31'b0, fail_o}, 32'd1);

    // Reset in the middle of data bit 4
    b = 8'h96;
    @(negedge clk);
    rx_i = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_i = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rx_i = b[4];
    repeat (Cpb / 2) @(negedge clk);
    do_reset();
    idle(40);

    // Back-to-back "xPASS", then "FAIL" must not change the verdict
    send_str("xPASS");
    idle(3);
    chk("pass_set", {31'b0, pass_o}, 32'd1);
    chk("fail_clear", {31'b0, fail_o}, 32'd0);
    send_str("FAIL");
    idle(20);
    chk("pass_kept", {31'b0, pass_o}, 32'd1);
    chk("fail_blocked", {31'b0, fail_o}, 32'd0);
    chk("count_9", byte_count_o, 32'd9);
    chk("count2_final", count2, 32'd3);

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 1000) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("drain", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
